alu_seq_ctrl: RTL and testbench

Sequencer and two-port arbiter for the shared 4-bit ALU datapath. Two requesters submit operations (select code plus operands) over valid/ready handshakes. The block grants them round-robin, drives the ALU's `enable`/`select`/operand inputs for one issue cycle, and waits a fixed latency. It then captures the wrapper-muxed result and returns it, tagged with the requester ID, on a buffered response port.

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/alu_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: FSM states, ALU select codes, result width.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADDSUB  = 4'd0;
  localparam logic [3:0] OP_CMP     = 4'd1;
  localparam logic [3:0] OP_B2G     = 4'd2;
  localparam logic [3:0] OP_AND     = 4'd3;
  localparam logic [3:0] OP_ANDR    = 4'd4;
  localparam logic [3:0] OP_OR      = 4'd5;
  localparam logic [3:0] OP_CMPL    = 4'd6;
  localparam logic [3:0] OP_INC     = 4'd7;
  localparam logic [3:0] OP_DEC     = 4'd8;
  localparam logic [3:0] OP_PAR     = 4'd9;
  localparam logic [3:0] OP_ORR     = 4'd10;
  localparam logic [3:0] OP_MUL     = 4'd11;
  localparam logic [3:0] OP_G2B     = 4'd12;
  localparam logic [3:0] OP_VADD    = 4'd13;
  localparam logic [3:0] OP_VMUL    = 4'd14;
  localparam logic [3:0] OP_ILLEGAL = 4'd15;

  localparam int unsigned RES_W_DEF = 16;

  function automatic logic op_legal(input logic [3:0] op);
    return op != OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer moves past whichever requester was granted on advance.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = '0;
    if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
    else                grant = valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= 1'b0;
    else if (advance) ptr <= grant[0];
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer for the shared 4-bit ALU: arbitrates two requesters, issues one op, returns a tagged response.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned RES_W   = RES_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  input  logic             req1_cin,
  output logic             alu_enable,
  output logic [3:0]       alu_select,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic             alu_cin,
  input  logic [RES_W-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [3:0]       rsp_op,
  output logic [RES_W-1:0] rsp_data,
  output logic             rsp_err
);

  state_t     state, state_nxt;
  logic [1:0] grant;
  logic       idle, accept, sel_id, legal, last;
  logic [3:0] acc_op;
  logic [7:0] acc_a, acc_b;
  logic       acc_cin;
  logic [2:0] cnt;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  ({req1_valid, req0_valid}),
    .advance(accept),
    .grant  (grant)
  );

  // Readies are gated by rst_n so they read 0 throughout reset even with requests present.
  assign idle       = (state == S_IDLE);
  assign req0_ready = idle && rst_n && grant[0];
  assign req1_ready = idle && rst_n && grant[1];
  assign accept     = req0_ready || req1_ready;
  assign sel_id     = grant[1];
  assign acc_op     = sel_id ? req1_op  : req0_op;
  assign acc_a      = sel_id ? req1_a   : req0_a;
  assign acc_b      = sel_id ? req1_b   : req0_b;
  assign acc_cin    = sel_id ? req1_cin : req0_cin;
  assign legal      = op_legal(acc_op);
  assign last       = (cnt == 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = legal ? S_ISSUE : S_RESP;
      S_ISSUE: state_nxt = last ? S_RESP : S_WAIT;
      S_WAIT:  if (last) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The issue cycle counts as the first latency cycle, so enable spans exactly ALU_LAT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_enable <= 1'b0;
      alu_select <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_op     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            rsp_id   <= sel_id;
            rsp_op   <= acc_op;
            rsp_data <= '0;
            rsp_err  <= !legal;
            cnt      <= 3'(ALU_LAT - 1);
            if (legal) begin
              alu_enable <= 1'b1;
              alu_select <= acc_op;
              alu_a      <= acc_a;
              alu_b      <= acc_b;
              alu_cin    <= acc_cin;
            end else begin
              rsp_valid <= 1'b1;
            end
          end
        end
        S_ISSUE, S_WAIT: begin
          if (last) begin
            rsp_data   <= alu_result;
            rsp_valid  <= 1'b1;
            alu_enable <= 1'b0;
            alu_select <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cin    <= 1'b0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: one instance at ALU_LAT=1, one at ALU_LAT=3, with simple wrapper result models.
module tb_alu_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Instance with ALU_LAT=1
  logic       req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
  logic [3:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       alu_enable, alu_cin, rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [3:0] alu_select, rsp_op;
  logic [7:0] alu_a, alu_b;
  logic [15:0] alu_result, rsp_data;

  // Instance with ALU_LAT=3 (only requester 0 used)
  logic       b_valid, b_ready, b_ready1, b_en, b_cin, b_rsp_valid, b_rsp_id, b_rsp_err;
  logic [3:0] b_op, b_sel, b_rsp_op;
  logic [7:0] b_a, b_b, b_alu_a, b_alu_b;
  logic [15:0] b_result, b_rsp_data;
  int unsigned b_en_cnt;

  alu_seq_ctrl #(.ALU_LAT(1), .RES_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .alu_enable(alu_enable), .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_op(rsp_op),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  alu_seq_ctrl #(.ALU_LAT(3), .RES_W(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_valid), .req0_ready(b_ready), .req0_op(b_op),
    .req0_a(b_a), .req0_b(b_b), .req0_cin(1'b0),
    .req1_valid(1'b0), .req1_ready(b_ready1), .req1_op(4'd0),
    .req1_a(8'd0), .req1_b(8'd0), .req1_cin(1'b0),
    .alu_enable(b_en), .alu_select(b_sel), .alu_a(b_alu_a), .alu_b(b_alu_b),
    .alu_cin(b_cin), .alu_result(b_result),
    .rsp_valid(b_rsp_valid), .rsp_ready(1'b1), .rsp_id(b_rsp_id), .rsp_op(b_rsp_op),
    .rsp_data(b_rsp_data), .rsp_err(b_rsp_err)
  );

  // Wrapper model for the 1-cycle ALU: nibble add, nibble AND, nibble multiply.
  always_comb begin
    alu_result = '0;
    if (alu_enable) begin
      case (alu_select)
        4'd0:    alu_result = 16'(alu_a[3:0]) + 16'(alu_b[3:0]) + 16'(alu_cin);
        4'd3:    alu_result = 16'(alu_a[3:0] & alu_b[3:0]);
        4'd11:   alu_result = 16'(alu_a[3:0]) * 16'(alu_b[3:0]);
        default: alu_result = 16'hFFFF;
      endcase
    end
  end

  // 3-cycle ALU model: the product is only valid in the third enable cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     b_en_cnt <= 0;
    else if (b_en)  b_en_cnt <= b_en_cnt + 1;
    else            b_en_cnt <= 0;
  end
  always_comb begin
    b_result = 16'hBAD0;
    if (b_en && b_en_cnt == 2) b_result = 16'(b_alu_a[3:0]) * 16'(b_alu_b[3:0]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 8'h05; req0_b = 8'h03; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_op = 4'd0; req1_a = 8'h00; req1_b = 8'h00; req1_cin = 1'b0;
    b_valid = 1'b0; b_op = 4'd0; b_a = 8'h00; b_b = 8'h00;
    #12;
    chk("rst_enable", alu_enable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_b_enable", b_en, 0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single add on requester 0 with ALU_LAT=1
    req0_valid = 1'b1;
    #1;
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    chk("t1_enable", alu_enable, 1);
    chk("t1_select", alu_select, 0);
    chk("t1_a", alu_a, 8'h05);
    chk("t1_rsp_valid_early", rsp_valid, 0);
    tick();
    chk("t1_enable_off", alu_enable, 0);
    chk("t1_select_zero", alu_select, 0);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_data", rsp_data, 16'h0008);
    chk("t1_rsp_err", rsp_err, 0);
    tick();
    chk("t1_rsp_done", rsp_valid, 0);

    // Illegal op on requester 1
    req1_valid = 1'b1; req1_op = 4'd15; req1_a = 8'h77; req1_b = 8'h22;
    #1;
    chk("t2_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rsp_err", rsp_err, 1);
    chk("t2_rsp_data", rsp_data, 0);
    chk("t2_rsp_id", rsp_id, 1);
    chk("t2_rsp_op", rsp_op, 4'hF);
    chk("t2_enable", alu_enable, 0);
    tick();
    chk("t2_rsp_done", rsp_valid, 0);
    chk("t2_enable_after", alu_enable, 0);

    // Backpressure: AND 0x0E & 0x07 = 6, response held 10 cycles
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd3; req0_a = 8'h0E; req0_b = 8'h07;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("t3_rsp_valid", rsp_valid, 1);
    chk("t3_rsp_data", rsp_data, 16'h0006);
    req0_valid = 1'b1; req1_valid = 1'b1; req1_op = 4'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold_valid", rsp_valid, 1);
      chk("t3_hold_data", rsp_data, 16'h0006);
      chk("t3_hold_id", rsp_id, 0);
      chk("t3_hold_op", rsp_op, 4'd3);
      chk("t3_hold_ready0", req0_ready, 0);
      chk("t3_hold_ready1", req1_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    // Grant history 0,1,0 leaves the pointer on requester 1
    chk("t3_resume_ready1", req1_ready, 1);
    chk("t3_resume_ready0", req0_ready, 0);
    chk("t3_resume_rsp_valid", rsp_valid, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // ALU_LAT=3 multiply 0x0F*0x0F = 0xE1
    b_valid = 1'b1; b_op = 4'd11; b_a = 8'h0F; b_b = 8'h0F;
    #1;
    chk("t4_ready", b_ready, 1);
    tick();
    b_valid = 1'b0; b_a = 8'h00;
    chk("t4_en_c1", b_en, 1);
    chk("t4_sel", b_sel, 4'd11);
    tick();
    chk("t4_en_c2", b_en, 1);
    chk("t4_a_stable", b_alu_a, 8'h0F);
    tick();
    chk("t4_en_c3", b_en, 1);
    chk("t4_rsp_valid_early", b_rsp_valid, 0);
    tick();
    chk("t4_en_off", b_en, 0);
    chk("t4_rsp_valid", b_rsp_valid, 1);
    chk("t4_rsp_data", b_rsp_data, 16'h00E1);
    chk("t4_rsp_op", b_rsp_op, 4'd11);
    tick();
    chk("t4_rsp_done", b_rsp_valid, 0);

    // Reset pulsed while the ALU_LAT=3 instance is in WAIT
    b_valid = 1'b1; b_op = 4'd11; b_a = 8'h03; b_b = 8'h05;
    tick();
    b_valid = 1'b0;
    tick();
    chk("t5_en_before", b_en, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_en_async", b_en, 0);
    chk("t5_rsp_async", b_rsp_valid, 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_rsp", b_rsp_valid, 0);
      chk("t5_no_en", b_en, 0);
    end

    // Alternating grants after reset: req0 add (a+1), req1 multiply (a*3)
    req0_valid = 1'b1; req0_op = 4'd0;  req0_a = 8'h01; req0_b = 8'h01; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_op = 4'd11; req1_a = 8'h01; req1_b = 8'h03; req1_cin = 1'b0;
    for (int k = 0; k < 8; k++) begin
      int e;
      int j;
      e = k % 2;
      j = k / 2;
      #1;
      chk("t6_ready0", req0_ready, (e == 0) ? 1 : 0);
      chk("t6_ready1", req1_ready, (e == 1) ? 1 : 0);
      tick();
      if (e == 0) req0_a = 8'(j + 2);
      else        req1_a = 8'(j + 2);
      chk("t6_enable", alu_enable, 1);
      tick();
      chk("t6_rsp_valid", rsp_valid, 1);
      chk("t6_rsp_id", rsp_id, e);
      chk("t6_rsp_data", rsp_data, (e == 0) ? (j + 2) : ((j + 1) * 3));
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("t6_idle_rsp", rsp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
